// File: rtl/snd_latch_pkg.sv
// Shared sizing defaults and read-FSM state encoding for the sound command latch.
package snd_latch_pkg;
  localparam int SND_DW    = 8;
  localparam int SND_DEPTH = 4;
  localparam int SND_AW    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rd_state_t;
endpackage

// File: rtl/strobe_edge_det.sv
// Rising-edge detector. Combinational pulse the cycle a level is first seen high.
// RST_VAL=1 makes a level already high when reset releases look old, so no edge is reported.
module strobe_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);
  logic sig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sig_q <= RST_VAL;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/sound_latch_reader.sv
// Main-to-sound CPU command queue: edge-triggered writes, one pop per completed read cycle.
// RD_Q is frozen for the whole read; IRQn is low while any byte is queued.
import snd_latch_pkg::*;

module sound_latch_reader #(
  parameter int DW    = SND_DW,
  parameter int DEPTH = SND_DEPTH,
  parameter int AW    = SND_AW
) (
  input  logic          Clk,
  input  logic          RESET,
  input  logic          WR_STB,
  input  logic [DW-1:0] WR_D,
  input  logic          RD_CS,
  input  logic          CLR,
  output logic [DW-1:0] RD_Q,
  output logic          IRQn,
  output logic [AW:0]   COUNT,
  output logic          OVF
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] rd_q_q;
  logic          ovf_q, irqn_q;
  rd_state_t     state_q, state_d;
  logic          wr_edge, rd_fall, is_full, push, pop;

  strobe_edge_det #(.RST_VAL(1'b1)) u_wr_edge (
    .clk_i  (Clk),
    .rst_i  (RESET),
    .sig_i  (WR_STB),
    .rise_o (wr_edge)
  );

  // Rising edge of ~RD_CS is the end of a read bus cycle.
  strobe_edge_det #(.RST_VAL(1'b1)) u_rd_fall (
    .clk_i  (Clk),
    .rst_i  (RESET),
    .sig_i  (~RD_CS),
    .rise_o (rd_fall)
  );

  assign is_full = (count_q == (AW+1)'(DEPTH));
  assign pop     = (state_q == HOLD) && rd_fall && (count_q != '0);
  // A pop in the same cycle frees a slot, so a write into a full queue still lands.
  assign push    = wr_edge && (!is_full || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (RD_CS)  state_d = HOLD;
      HOLD:    if (!RD_CS) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (CLR) state_d = IDLE;
  end

  always_comb begin
    count_d = count_q;
    if (CLR)              count_d = '0;
    else if (push && !pop) count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge Clk) begin
    if (push && !CLR) mem_q[wr_ptr_q] <= WR_D;
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_q_q   <= '0;
      ovf_q    <= 1'b0;
      irqn_q   <= 1'b1;
      state_q  <= IDLE;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      irqn_q  <= (count_d == '0);
      if (CLR) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (wr_edge && is_full && !pop) ovf_q <= 1'b1;
        if (state_q == IDLE && count_q != '0) rd_q_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign RD_Q  = rd_q_q;
  assign IRQn  = irqn_q;
  assign COUNT = count_q;
  assign OVF   = ovf_q;
endmodule

// File: tb/tb_sound_latch_reader.sv
// Directed bench: stimulus queues expected read data and status checks; a negedge monitor compares.
module tb_sound_latch_reader;
  logic       Clk = 1'b0;
  logic       RESET, WR_STB, RD_CS, CLR;
  logic [7:0] WR_D;
  logic [7:0] RD_Q;
  logic       IRQn, OVF;
  logic [2:0] COUNT;

  sound_latch_reader dut (
    .Clk(Clk), .RESET(RESET), .WR_STB(WR_STB), .WR_D(WR_D), .RD_CS(RD_CS),
    .CLR(CLR), .RD_Q(RD_Q), .IRQn(IRQn), .COUNT(COUNT), .OVF(OVF)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    int         kind;   // 0 COUNT, 1 IRQn, 2 OVF, 3 RD_Q
    logic [7:0] exp;
  } chk_t;

  chk_t       st_q[$];
  logic [7:0] rd_exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       rd_prev = 1'b0;
  chk_t       c;
  logic [7:0] act;

  always @(negedge Clk) begin
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycles=%0d required below 20000", cyc);
      $fatal(1, "watchdog expired");
    end
    while (st_q.size() > 0) begin
      c = st_q.pop_front();
      case (c.kind)
        0:       act = {5'b0, COUNT};
        1:       act = {7'b0, IRQn};
        2:       act = {7'b0, OVF};
        default: act = RD_Q;
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %02h expected %02h", c.name, act, c.exp);
      end
    end
    if (RD_CS && rd_prev) begin
      total++;
      if (rd_exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_data: got %02h expected none queued", RD_Q);
      end else if (RD_Q !== rd_exp_q[0]) begin
        bad++;
        $display("FAIL rd_data: got %02h expected %02h", RD_Q, rd_exp_q[0]);
      end
    end
    if (!RD_CS && rd_prev && rd_exp_q.size() > 0) void'(rd_exp_q.pop_front());
    rd_prev = RD_CS;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_st(input string n, input int k, input logic [7:0] e);
    chk_t r;
    r.name = n;
    r.kind = k;
    r.exp  = e;
    st_q.push_back(r);
  endtask

  task automatic wr(input logic [7:0] d);
    WR_D = d;
    WR_STB = 1'b1;
    tick();
    WR_STB = 1'b0;
    tick();
  endtask

  task automatic rd(input int n, input logic [7:0] e);
    rd_exp_q.push_back(e);
    RD_CS = 1'b1;
    repeat (n) tick();
    RD_CS = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] fill [4];
    RESET = 1'b1; WR_STB = 1'b1; RD_CS = 1'b0; CLR = 1'b0; WR_D = 8'h00;

    // 1: reset with strobe held high
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    expect_st("rst_irqn", 1, 8'h01);
    expect_st("rst_count", 0, 8'h00);
    expect_st("rst_ovf", 2, 8'h00);
    expect_st("rst_rdq", 3, 8'h00);
    tick(); tick();
    expect_st("held_stb_count", 0, 8'h00);
    WR_STB = 1'b0;
    tick();

    // 2: single write / read
    WR_D = 8'h5A; WR_STB = 1'b1;
    tick();
    expect_st("wr1_irqn", 1, 8'h00);
    expect_st("wr1_count", 0, 8'h01);
    WR_STB = 1'b0;
    tick();
    rd(3, 8'h5A);
    expect_st("rd1_count", 0, 8'h00);
    expect_st("rd1_irqn", 1, 8'h01);

    // 3: fill and overflow
    for (int i = 1; i <= 5; i++) wr(8'(i));
    expect_st("full_count", 0, 8'h04);
    expect_st("full_ovf", 2, 8'h01);
    for (int i = 1; i <= 4; i++) rd(2, 8'(i));
    expect_st("drain_count", 0, 8'h00);
    expect_st("drain_irqn", 1, 8'h01);
    expect_st("ovf_sticky", 2, 8'h01);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    expect_st("clr_ovf", 2, 8'h00);
    expect_st("clr_rdq_kept", 3, 8'h04);
    tick();

    // 4: RD_Q stable while a write lands mid-read
    wr(8'h11);
    rd_exp_q.push_back(8'h11);
    RD_CS = 1'b1;
    tick(); tick();
    wr(8'h22);
    tick();
    RD_CS = 1'b0;
    tick();
    tick();
    expect_st("after_pop_rdq", 3, 8'h22);
    expect_st("after_pop_count", 0, 8'h01);
    rd(2, 8'h22);

    // 5: full queue, write edge in the same clock as the read ends
    fill = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) wr(fill[i]);
    expect_st("pre_sim_count", 0, 8'h04);
    rd_exp_q.push_back(8'hA1);
    RD_CS = 1'b1;
    tick(); tick();
    RD_CS = 1'b0; WR_D = 8'hB5; WR_STB = 1'b1;
    tick();
    WR_STB = 1'b0;
    tick();
    expect_st("sim_count", 0, 8'h04);
    expect_st("sim_ovf", 2, 8'h00);
    rd(2, 8'hA2);
    rd(2, 8'hA3);
    rd(2, 8'hA4);
    rd(2, 8'hB5);
    expect_st("sim_drain_count", 0, 8'h00);

    // 6: empty read, then CLR in the middle of a read
    rd(3, 8'hB5);
    expect_st("empty_rd_count", 0, 8'h00);
    expect_st("empty_rd_irqn", 1, 8'h01);
    wr(8'hC1);
    wr(8'hC2);
    expect_st("two_count", 0, 8'h02);
    expect_st("two_irqn", 1, 8'h00);
    rd_exp_q.push_back(8'hC1);
    RD_CS = 1'b1;
    tick(); tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    tick();
    expect_st("clr_rd_count", 0, 8'h00);
    expect_st("clr_rd_irqn", 1, 8'h01);
    RD_CS = 1'b0;
    tick();
    tick();
    expect_st("clr_end_count", 0, 8'h00);
    expect_st("clr_end_ovf", 2, 8'h00);
    expect_st("clr_end_rdq", 3, 8'hC1);
    wr(8'hD7);
    expect_st("post_clr_count", 0, 8'h01);
    rd(2, 8'hD7);
    expect_st("post_clr_drain", 0, 8'h00);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
